// File: rtl/frame_seq_pkg.sv
// frame_seq_pkg
// Shared definitions for the animation frame sequencer:
//   - FRAME_SIZE_DEFAULT : ROM words per animation frame (800 x 352)
//   - IDX_W_DEFAULT      : width of the frame index and config fields
//   - mode_e             : playback mode encoding driven on mode_i
//   - state_e            : sequencer FSM states
//   - base_op_e          : how the ROM base address moves on a frame change
package frame_seq_pkg;

  localparam int unsigned FRAME_SIZE_DEFAULT = 281600;
  localparam int unsigned IDX_W_DEFAULT      = 8;

  // 2'b11 is not a distinct mode; it falls into the loop behaviour
  typedef enum logic [1:0] {
    MODE_LOOP     = 2'b00,
    MODE_PINGPONG = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_LOOP_ALT = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The base address is tracked alongside the index so no multiplier is needed
  typedef enum logic [1:0] {
    BASE_HOLD = 2'd0,
    BASE_INC  = 2'd1,
    BASE_DEC  = 2'd2,
    BASE_ZERO = 2'd3
  } base_op_e;

endpackage

// File: rtl/frame_sequencer.sv
// frame_sequencer
// Steps an animation through a ROM of frames, one decision per vertical
// blank rising edge. Supports loop, ping-pong and one-shot playback, a
// per-frame vblank delay, pause with single-frame stepping, and tracks
// the ROM base address of the current frame incrementally.
//
// Ports:
//   clk_i          : clock, all logic on the rising edge
//   rst_ni         : asynchronous active-low reset
//   cen_i          : video clock enable; nothing advances while low
//   vblank_i       : vertical blank level
//   play_i         : 1 = run the animation, 0 = pause
//   step_i         : single-frame advance request while paused
//   mode_i         : 00 loop, 01 ping-pong, 10 one-shot, 11 loop
//   delay_i        : vblanks per frame (0 behaves as 1)
//   num_frames_i   : frames in the sequence (0 behaves as 1)
//   frame_idx_o    : current frame index
//   frame_base_o   : ROM base address of the current frame
//   frame_tick_o   : one-cen-period pulse when the frame index changes
//   done_o         : high while a finished one-shot is being held
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int unsigned FRAME_SIZE = FRAME_SIZE_DEFAULT,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned IDX_W      = IDX_W_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cen_i,
  input  logic              vblank_i,
  input  logic              play_i,
  input  logic              step_i,
  input  logic [1:0]        mode_i,
  input  logic [IDX_W-1:0]  delay_i,
  input  logic [IDX_W-1:0]  num_frames_i,
  output logic [IDX_W-1:0]  frame_idx_o,
  output logic [ADDR_W-1:0] frame_base_o,
  output logic              frame_tick_o,
  output logic              done_o
);

  localparam logic [ADDR_W-1:0] FRAME_STEP = ADDR_W'(FRAME_SIZE);
  localparam logic [IDX_W-1:0]  IDX_ONE    = {{(IDX_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  mode_e             mode_sh_q, mode_eff;
  logic [IDX_W-1:0]  delay_sh_q, nf_sh_q;
  logic [IDX_W-1:0]  delay_in, nf_in, delay_eff, nf_eff, nf_last;
  logic [IDX_W-1:0]  idx_q, idx_d, cnt_q, cnt_d;
  logic [IDX_W:0]    cnt_inc;
  logic [ADDR_W-1:0] base_q;
  base_op_e          base_op;
  logic              dir_down_q, dir_down_d;
  logic              step_pend_q, step_pend_d;
  logic              vblank_d_q, tick_q;
  logic              rise, advance, restart, shrink, at_last, oneshot_end;

  assign rise = cen_i & vblank_i & ~vblank_d_q;

  assign delay_in = (delay_i == '0)      ? IDX_ONE : delay_i;
  assign nf_in    = (num_frames_i == '0) ? IDX_ONE : num_frames_i;

  // On a rise the freshly presented config is what gets latched, so that
  // same rise already decides with it; between rises the shadows hold.
  assign mode_eff  = rise ? mode_e'(mode_i) : mode_sh_q;
  assign delay_eff = rise ? delay_in        : delay_sh_q;
  assign nf_eff    = rise ? nf_in           : nf_sh_q;

  assign nf_last     = nf_eff - IDX_ONE;
  assign at_last     = (idx_q == nf_last);
  assign shrink      = rise & (idx_q >= nf_eff);
  assign cnt_inc     = {1'b0, cnt_q} + {{IDX_W{1'b0}}, 1'b1};
  assign oneshot_end = (mode_eff == MODE_ONESHOT) &
                       (at_last | ((idx_q + IDX_ONE) == nf_last));

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control: play/pause transitions, the per-frame delay
  // counter, and stepping while paused. A step seen on the same cen cycle
  // as the rise is honoured by that rise.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    step_pend_d = step_pend_q;
    advance     = 1'b0;
    restart     = 1'b0;
    if (cen_i) begin
      if (!rise) begin
        step_pend_d = (state_q == ST_IDLE) & (step_pend_q | step_i);
      end else begin
        step_pend_d = 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (play_i) begin
              state_d = ST_PLAY;
              cnt_d   = '0;
            end else begin
              advance = step_pend_q | step_i;
            end
          end
          ST_PLAY: begin
            if (!play_i) begin
              state_d = ST_IDLE;
            end else if (cnt_inc >= {1'b0, delay_eff}) begin
              advance = 1'b1;
              cnt_d   = '0;
              if (oneshot_end && !shrink) begin
                state_d = ST_DONE;
              end
            end else begin
              cnt_d = cnt_inc[IDX_W-1:0];
            end
          end
          ST_DONE: begin
            if (!play_i) begin
              state_d = ST_IDLE;
              restart = 1'b1;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Frame index / direction update. A shrunk sequence or a one-shot being
  // re-armed snaps back to frame 0 heading up.
  always_comb begin
    idx_d      = idx_q;
    dir_down_d = dir_down_q;
    base_op    = BASE_HOLD;
    if (shrink || restart) begin
      idx_d      = '0;
      dir_down_d = 1'b0;
      base_op    = BASE_ZERO;
    end else if (advance) begin
      case (mode_eff)
        MODE_PINGPONG: begin
          if (nf_eff != IDX_ONE) begin
            if (dir_down_q ? (idx_q == '0) : !at_last) begin
              idx_d      = idx_q + IDX_ONE;
              dir_down_d = 1'b0;
              base_op    = BASE_INC;
            end else begin
              idx_d      = idx_q - IDX_ONE;
              dir_down_d = 1'b1;
              base_op    = BASE_DEC;
            end
          end
        end
        MODE_ONESHOT: begin
          if (!at_last) begin
            idx_d   = idx_q + IDX_ONE;
            base_op = BASE_INC;
          end
        end
        default: begin
          if (at_last) begin
            idx_d   = '0;
            base_op = BASE_ZERO;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            base_op = BASE_INC;
          end
        end
      endcase
    end
  end

  // Datapath registers. The tick is re-evaluated every cen cycle, so it
  // stays high exactly until the next enabled cycle after a change.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vblank_d_q  <= 1'b0;
      idx_q       <= '0;
      base_q      <= '0;
      tick_q      <= 1'b0;
      cnt_q       <= '0;
      dir_down_q  <= 1'b0;
      step_pend_q <= 1'b0;
      mode_sh_q   <= MODE_LOOP;
      delay_sh_q  <= IDX_ONE;
      nf_sh_q     <= IDX_ONE;
    end else if (cen_i) begin
      vblank_d_q  <= vblank_i;
      idx_q       <= idx_d;
      tick_q      <= (idx_d != idx_q);
      cnt_q       <= cnt_d;
      dir_down_q  <= dir_down_d;
      step_pend_q <= step_pend_d;
      case (base_op)
        BASE_INC:  base_q <= base_q + FRAME_STEP;
        BASE_DEC:  base_q <= base_q - FRAME_STEP;
        BASE_ZERO: base_q <= '0;
        default:   base_q <= base_q;
      endcase
      if (rise) begin
        mode_sh_q  <= mode_e'(mode_i);
        delay_sh_q <= delay_in;
        nf_sh_q    <= nf_in;
      end
    end
  end

  // Outputs
  always_comb begin
    done_o = (state_q == ST_DONE);
  end

  assign frame_idx_o  = idx_q;
  assign frame_base_o = base_q;
  assign frame_tick_o = tick_q;

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameter FRAME_SIZE, default 281600, ROM words per animation frame (800 x 352).
REQ-002 Parameter ADDR_W, default 32, width of frame_base_o.
REQ-003 Parameter IDX_W, default 8, width of frame index and config fields.
REQ-004 clk_i  in  1  single clock, all logic rising-edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 cen_i  in  1  video clock enable; all state advances only when high.
REQ-007 vblank_i  in  1  vertical blank (vh_blank[1]).
REQ-008 play_i  in  1  level; 1 = run animation, 0 = pause.
REQ-009 step_i  in  1  pulse; request a single-frame advance while paused.
REQ-010 mode_i  in  2  00 loop, 01 ping-pong, 10 one-shot, 11 treated as loop.
REQ-011 delay_i  in  IDX_W  vblanks per frame; 0 treated as 1.
REQ-012 num_frames_i  in  IDX_W  frames in sequence; 0 treated as 1.
REQ-013 frame_idx_o  out  IDX_W  current frame index.
REQ-014 frame_base_o  out  ADDR_W  ROM base address = frame_idx_o * FRAME_SIZE.
REQ-015 frame_tick_o  out  1  one-cen-period pulse when frame_idx_o changes.
REQ-016 done_o  out  1  high while one-shot sequence finished.

Function
REQ-017 Vblank rise = vblank_i & ~vblank_d, vblank_d registered on cen_i; all frame decisions occur only on a rise.
REQ-018 mode_i, delay_i, num_frames_i SHALL be latched into shadow registers on each rise and used from that rise onward; mid-frame changes have no effect until next rise.
REQ-019 States: IDLE, PLAY, DONE; reset state IDLE.
REQ-020 IDLE -> PLAY on rise with play_i=1; PLAY -> IDLE on rise with play_i=0; PLAY -> DONE on one-shot reaching last frame; DONE -> IDLE on rise with play_i=0.
REQ-021 PLAY: delay counter increments per rise; when count+1 >= delay, advance one frame and clear counter; counter also clears on entry to PLAY.
REQ-022 IDLE: step_i pulse (any cen cycle) sets step_pending; next rise advances exactly one frame and clears it; step_i ignored in PLAY and DONE.
REQ-023 Loop: after index num_frames-1, next index 0.
REQ-024 Ping-pong: direction flips at num_frames-1 (down) and at 0 (up); num_frames=1 holds index 0, no tick.
REQ-025 One-shot: advance to num_frames-1, then enter DONE holding last frame, done_o=1; leaving DONE via IDLE and replay restarts from index 0.
REQ-026 frame_base_o SHALL be maintained incrementally (+FRAME_SIZE, -FRAME_SIZE, or 0 on wrap); no multiplier.
REQ-027 If latched num_frames <= current index, index and base SHALL be forced to 0 on that rise, direction up, tick asserted.
REQ-028 frame_idx_o, frame_base_o update at the clock edge where the rise is detected; frame_tick_o high from that edge until next cen_i cycle.
REQ-029 frame_tick_o SHALL not assert when index is unchanged.

Reset
REQ-030 On rst_ni low, asynchronously: state IDLE, frame_idx_o 0, frame_base_o 0, frame_tick_o 0, done_o 0, delay counter 0, direction up, step_pending 0, vblank_d 0, shadows = loop/1/1.
REQ-031 Reset deassertion mid-frame SHALL not produce a tick before the first detected rise.

Structure
REQ-032 Shared package frame_seq_pkg holds the mode enum, state enum, FRAME_SIZE default, and IDX_W.
REQ-033 Single flat module; vblank edge detector inline, no sub-module.

Verification
REQ-034 Loop: num_frames=3, delay=2, play=1, 8 vblanks -> idx 0,0,1,1,2,2,0,0 pattern per rise; base 0,281600,563200,0.
REQ-035 Ping-pong: num_frames=3, delay=1, 6 rises -> idx 1,2,1,0,1,2.
REQ-036 One-shot: num_frames=2, delay=1 -> idx 1 on rise 1, done_o=1, idx held 1 on rises 2-5, no further tick.
REQ-037 Pause/step: play=0, step pulse mid-frame -> idx +1 at next rise only; two steps in one frame -> single advance.
REQ-038 Shrink: idx=5, num_frames changed to 4 mid-frame -> at next rise idx 0, base 0, tick=1.
REQ-039 Reset asserted mid-play at idx 7 -> outputs 0 immediately without clock; delay=0 and num_frames=0 behave as 1.
